mux_16_to_1: RTL and testbench

Registered 16-to-1 single-bit multiplexer. Selects one bit of a 16-bit data word by a 4-bit index and presents it on a registered output one clock after sampling. It is a leaf datapath block used wherever a single status/data bit must be picked from a 16-bit vector under control of an index. Combinational selection is followed by one output flop with asynchronous reset.

---
 rtl/mux_16_to_1.sv | 29 ++
 tb/tb_mux_16_to_1.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mux_16_to_1.sv
// Registered 16-to-1 single-bit multiplexer with sample enable.
// One 16:1 selection level feeding an async-reset output flop.
module mux_16_to_1 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] datain,
    input  logic [3:0]  select,
    output logic        outd,
    output logic        outd_valid
);

    logic sel_bit;

    // Plain index: X/Z select propagates X in simulation, no masking
    assign sel_bit = datain[select];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outd       <= 1'b0;
            outd_valid <= 1'b0;
        end else begin
            outd_valid <= en;
            if (en)
                outd <= sel_bit;
        end
    end

endmodule

// File: tb/tb_mux_16_to_1.sv
// Directed bench for mux_16_to_1 with a queue-based scoreboard.
// Expected outputs are queued at drive time and popped after the edge.
module tb_mux_16_to_1;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] datain;
    logic [3:0]  select;
    logic        outd;
    logic        outd_valid;

    int n_checks;
    int n_fail;
    logic [1:0] sb_q[$];

    mux_16_to_1 dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .datain     (datain),
        .select     (select),
        .outd       (outd),
        .outd_valid (outd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic obs,
                         input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one sampling edge, queue the expectation, compare after edge
    task automatic step(input string tag, input logic e,
                        input logic [15:0] d, input logic [3:0] s,
                        input logic exp_out);
        logic [1:0] got;
        @(negedge clk);
        en     = e;
        datain = d;
        select = s;
        sb_q.push_back({exp_out, e});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            got = sb_q.pop_front();
            check({tag, ".outd"}, outd, got[1]);
            check({tag, ".valid"}, outd_valid, got[0]);
        end
    endtask

    initial begin
        logic [15:0] d;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        en       = 1'b1;
        datain   = 16'hFFFF;
        select   = 4'd0;

        // Reset applied asynchronously before any clock edge
        #1;
        rst = 1'b1;
        #1;
        check("rst_async.outd", outd, 1'b0);
        check("rst_async.valid", outd_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold.outd", outd, 1'b0);
        check("rst_hold.valid", outd_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step("rst_release", 1'b1, 16'hFFFF, 4'd0, 1'b1);

        // Walking one
        for (int i = 0; i < 16; i++) begin
            d = 16'h0001 << i;
            for (int s = 0; s < 16; s++)
                step($sformatf("walk1_d%0d_s%0d", i, s), 1'b1, d,
                     4'(s), (s == i));
        end

        // Walking zero
        for (int i = 0; i < 16; i++) begin
            d = ~(16'h0001 << i);
            for (int s = 0; s < 16; s++)
                step($sformatf("walk0_d%0d_s%0d", i, s), 1'b1, d,
                     4'(s), (s != i));
        end

        // Enable hold
        step("en_load", 1'b1, 16'h8000, 4'd15, 1'b1);
        for (int k = 0; k < 3; k++)
            step($sformatf("en_hold%0d", k), 1'b0, 16'h8000, 4'd0, 1'b1);
        step("en_resume", 1'b1, 16'h8000, 4'd0, 1'b0);

        // Mid-stream reset between edges
        step("mid_pre", 1'b1, 16'h0020, 4'd5, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst.outd", outd, 1'b0);
        check("mid_rst.valid", outd_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step("mid_post", 1'b1, 16'h0020, 4'd5, 1'b1);

        // Simultaneous datain/select change
        step("simul_a", 1'b1, 16'h0004, 4'd2, 1'b1);
        step("simul_b", 1'b1, 16'h0008, 4'd3, 1'b1);
        step("simul_c", 1'b1, 16'h0008, 4'd2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
